cordic_rotator: RTL and testbench

Iterative rotation-mode CORDIC engine: accepts a vector (x, y) and an angle z in Q3.12, performs one micro-rotation per clock, and returns the rotated vector and residual angle. It sits directly downstream of the arctan constant ROM `cordic_constants`: it drives the ROM index with its iteration counter and consumes the returned angle in the same cycle. One operation is in flight at a time. Valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_rotator_if.sv | 28 ++
 rtl/cordic_micro_rotation.sv | 41 ++++
 rtl/cordic_rotator.sv | 149 ++++++++++++++
 tb/tb_cordic_rotator.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotator: data widths, the
// CORDIC gain constant, the Q3.12 data type, the FSM state type and the
// gain-scaling helper used when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;

    localparam logic [DATA_W-1:0] CORDIC_K = 16'h09B7;

    typedef logic signed [DATA_W-1:0] q3_12_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMP,
        DONE
    } cordic_state_t;

    // Signed 16x16 -> 32 product with K, arithmetic shift right by FRAC_W,
    // low DATA_W bits kept (truncation, wraps like the rest of the datapath).
    function automatic q3_12_t gain_scale(input q3_12_t v);
        logic signed [2*DATA_W-1:0] p;
        logic signed [2*DATA_W-1:0] s;
        p = v * $signed(CORDIC_K);
        s = p >>> FRAC_W;
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_rotator_if.sv
// Operand/result handshake bundle for cordic_rotator.
// slave: the engine side; master: the producer/consumer side.
interface cordic_rotator_if;
    import cordic_pkg::*;

    logic   in_valid;
    logic   in_ready;
    q3_12_t x_in;
    q3_12_t y_in;
    q3_12_t z_in;

    logic   out_valid;
    logic   out_ready;
    q3_12_t x_out;
    q3_12_t y_out;
    q3_12_t z_out;

    modport slave (
        input  in_valid, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out
    );

    modport master (
        output in_valid, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out
    );

endinterface

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation in rotation mode.
// Direction comes from the sign of z; both shifts use the incoming x and y.
// All arithmetic is 16-bit two's complement and wraps.
module cordic_micro_rotation
    import cordic_pkg::*;
(
    input  q3_12_t     i_x,
    input  q3_12_t     i_y,
    input  q3_12_t     i_z,
    input  logic [3:0] i_idx,
    input  q3_12_t     i_alpha,
    output q3_12_t     o_x,
    output q3_12_t     o_y,
    output q3_12_t     o_z
);

    q3_12_t w_xs;
    q3_12_t w_ys;
    logic   w_pos;

    assign w_xs  = i_x >>> i_idx;
    assign w_ys  = i_y >>> i_idx;
    assign w_pos = ~i_z[DATA_W-1];

    // Rotate towards z = 0: d=+1 for non-negative z, d=-1 otherwise.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (w_pos) begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_alpha;
        end else begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_alpha;
        end
    end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC engine, one micro-rotation per clock.
// Drives the external arctan ROM index from its iteration counter and uses
// the returned angle combinationally in the same cycle.
// Optional macro: CORDIC_GAIN_COMP_EN adds a one-cycle COMP state that
// scales x and y by K so results are true-magnitude rotations.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int unsigned ITERS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_rotator_if.slave   bus,
    output logic [3:0]        rom_idx,
    input  logic [DATA_W-1:0] rom_alpha
);

    cordic_state_t r_state;
    cordic_state_t w_state_next;

    q3_12_t     r_x;
    q3_12_t     r_y;
    q3_12_t     r_z;
    q3_12_t     w_x_next;
    q3_12_t     w_y_next;
    q3_12_t     w_z_next;
    q3_12_t     r_x_out;
    q3_12_t     r_y_out;
    q3_12_t     r_z_out;
    logic [3:0] r_i;

    logic w_in_ready;
    logic w_accept;
    logic w_last;

    assign w_in_ready = rst_n && (r_state == IDLE);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_i == 4'(ITERS - 1));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;
    assign bus.z_out     = r_z_out;
    assign rom_idx       = r_i;

    cordic_micro_rotation u_micro (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_idx   (r_i),
        .i_alpha ($signed(rom_alpha)),
        .o_x     (w_x_next),
        .o_y     (w_y_next),
        .o_z     (w_z_next)
    );

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, hold DONE until taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
`ifdef CORDIC_GAIN_COMP_EN
                    w_state_next = COMP;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                w_state_next = DONE;
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Working registers, iteration counter and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x <= bus.x_in;
                        r_y <= bus.y_in;
                        r_z <= bus.z_in;
                        r_i <= '0;
                    end
                end
                RUN: begin
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    r_z <= w_z_next;
                    if (w_last) begin
                        r_i <= '0;
`ifndef CORDIC_GAIN_COMP_EN
                        r_x_out <= w_x_next;
                        r_y_out <= w_y_next;
                        r_z_out <= w_z_next;
`endif
                    end else begin
                        r_i <= r_i + 4'd1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    r_x_out <= gain_scale(r_x);
                    r_y_out <= gain_scale(r_y);
                    r_z_out <= r_z;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed angle cases, random
// operands against a plain-arithmetic reference, backpressure, mid-operation
// reset, and a 16-iteration instance for the full ROM index range.
// Honors CORDIC_GAIN_COMP_EN the same way the design does.
module tb_cordic_rotator;
    import cordic_pkg::*;

    localparam int ITERS_A = 13;
    localparam int ITERS_B = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
    localparam bit GAIN  = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam bit GAIN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_rotator_if bus_a ();
    cordic_rotator_if bus_b ();

    logic [3:0]  idx_a;
    logic [3:0]  idx_b;
    logic [15:0] alpha_a;
    logic [15:0] alpha_b;

    int errors = 0;
    int checks = 0;

    // arctan(2^-i) in Q3.12; entries 13..15 are zero.
    function automatic logic [15:0] atan_rom(input logic [3:0] i);
        case (i)
            4'd0:    return 16'd3217;
            4'd1:    return 16'd1899;
            4'd2:    return 16'd1003;
            4'd3:    return 16'd509;
            4'd4:    return 16'd256;
            4'd5:    return 16'd128;
            4'd6:    return 16'd64;
            4'd7:    return 16'd32;
            4'd8:    return 16'd16;
            4'd9:    return 16'd8;
            4'd10:   return 16'd4;
            4'd11:   return 16'd2;
            4'd12:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    assign alpha_a = atan_rom(idx_a);
    assign alpha_b = atan_rom(idx_b);

    cordic_rotator #(.ITERS(ITERS_A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .rom_idx   (idx_a),
        .rom_alpha (alpha_a)
    );

    cordic_rotator #(.ITERS(ITERS_B)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .rom_idx   (idx_b),
        .rom_alpha (alpha_b)
    );

    function automatic int s16(input logic [15:0] v);
        return int'(shortint'(v));
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp, input int tol);
        checks++;
        if (obs - exp > tol || exp - obs > tol) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: n rotation steps with integer arithmetic and 16-bit wrap,
    // optionally followed by the K scaling.
    task automatic ref_rotate(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] z0,
                              input int n, input bit comp,
                              output int xr, output int yr, output int zr);
        shortint x, y, z;
        int d, nx, ny, nz;
        x = shortint'(x0);
        y = shortint'(y0);
        z = shortint'(z0);
        for (int k = 0; k < n; k++) begin
            d  = (z < 0) ? -1 : 1;
            nx = int'(x) - d * int'(y >>> k);
            ny = int'(y) + d * int'(x >>> k);
            nz = int'(z) - d * int'(atan_rom(4'(k)));
            x  = shortint'(nx);
            y  = shortint'(ny);
            z  = shortint'(nz);
        end
        if (comp) begin
            x = shortint'((int'(x) * int'(CORDIC_K)) >>> 12);
            y = shortint'((int'(y) * int'(CORDIC_K)) >>> 12);
        end
        xr = int'(x);
        yr = int'(y);
        zr = int'(z);
    endtask

    // Full operation on the 13-iteration instance, with `hold` cycles of
    // out_ready low once the result is up.
    task automatic run_a(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input int hold, input string tag,
                         output int xo, output int yo, output int zo);
        int ex, ey, ez;
        int lat;
        ref_rotate(x, y, z, ITERS_A, GAIN, ex, ey, ez);
        @(negedge clk);
        bus_a.x_in      = x;
        bus_a.y_in      = y;
        bus_a.z_in      = z;
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = 1'b0;
        for (int w = 0; w < 8 && !bus_a.in_ready; w++) @(negedge clk);
        check_eq({tag, ":accept_ready"}, int'(bus_a.in_ready), 1, 0);
        @(posedge clk);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= ITERS_A + 10; c++) begin
            if (bus_a.out_valid) begin
                lat = c;
                break;
            end
            if (c <= ITERS_A) check_eq({tag, ":rom_idx"}, int'(idx_a), c - 1, 0);
            @(negedge clk);
        end
        check_eq({tag, ":latency"}, lat, ITERS_A + 1 + EXTRA, 0);
        check_eq({tag, ":x"}, s16(bus_a.x_out), ex, 0);
        check_eq({tag, ":y"}, s16(bus_a.y_out), ey, 0);
        check_eq({tag, ":z"}, s16(bus_a.z_out), ez, 0);
        check_eq({tag, ":busy_ready"}, int'(bus_a.in_ready), 0, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, ":bp_valid"}, int'(bus_a.out_valid), 1, 0);
            check_eq({tag, ":bp_x"}, s16(bus_a.x_out), ex, 0);
            check_eq({tag, ":bp_y"}, s16(bus_a.y_out), ey, 0);
            check_eq({tag, ":bp_z"}, s16(bus_a.z_out), ez, 0);
            check_eq({tag, ":bp_ready"}, int'(bus_a.in_ready), 0, 0);
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        check_eq({tag, ":post_ready"}, int'(bus_a.in_ready), 1, 0);
        check_eq({tag, ":post_valid"}, int'(bus_a.out_valid), 0, 0);
        check_eq({tag, ":hold_x"}, s16(bus_a.x_out), ex, 0);
        xo = s16(bus_a.x_out);
        yo = s16(bus_a.y_out);
        zo = s16(bus_a.z_out);
    endtask

    initial begin
        int xo, yo, zo;
        int ex, ey, ez, ex13, ey13, ez13;
        int lat, hits;
        logic [15:0] rx, ry, rz;

        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
        bus_a.x_in = '0; bus_a.y_in = '0; bus_a.z_in = '0;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
        bus_b.x_in = '0; bus_b.y_in = '0; bus_b.z_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst:in_ready", int'(bus_a.in_ready), 0, 0);
        check_eq("rst:out_valid", int'(bus_a.out_valid), 0, 0);
        check_eq("rst:x_out", s16(bus_a.x_out), 0, 0);
        check_eq("rst:rom_idx", int'(idx_a), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst:release_ready", int'(bus_a.in_ready), 1, 0);

`ifndef CORDIC_GAIN_COMP_EN
        // 30 degrees with pre-scaled input, five cycles of backpressure
        run_a(16'h09B7, 16'h0000, 16'h0861, 5, "rot30", xo, yo, zo);
        check_eq("rot30:x_approx", xo, 16'h0DDB, 4);
        check_eq("rot30:y_approx", yo, 16'h0800, 4);
        check_eq("rot30:z_approx", zo, 0, 2);
        // -45 degrees
        run_a(16'h09B7, 16'h0000, 16'hF36F, 0, "rotm45", xo, yo, zo);
        check_eq("rotm45:x_approx", xo, 16'h0B50, 4);
        check_eq("rotm45:y_approx", yo, s16(16'hF4B0), 4);
`else
        // Identity and 30 degrees with unit input, gain removed in hardware
        run_a(16'h1000, 16'h0000, 16'h0000, 5, "ident", xo, yo, zo);
        check_eq("ident:x_approx", xo, 16'h1000, 4);
        check_eq("ident:y_approx", yo, 0, 4);
        run_a(16'h1000, 16'h0000, 16'h0861, 0, "rot30k", xo, yo, zo);
        check_eq("rot30k:x_approx", xo, 16'h0DDB, 4);
        check_eq("rot30k:y_approx", yo, 16'h0800, 4);
`endif

        // Random operands inside the caller range
        for (int n = 0; n < 8; n++) begin
            rx = 16'(int'($urandom_range(16384)) - 8192);
            ry = 16'(int'($urandom_range(16384)) - 8192);
            rz = 16'(int'($urandom_range(14254)) - 7127);
            run_a(rx, ry, rz, int'($urandom_range(2)), "rand", xo, yo, zo);
        end

        // Reset in the middle of RUN at iteration 6
        @(negedge clk);
        bus_a.x_in = 16'h0A00; bus_a.y_in = 16'h0300; bus_a.z_in = 16'h0400;
        bus_a.in_valid = 1'b1;
        for (int w = 0; w < 8 && !bus_a.in_ready; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        for (int w = 0; w < 20 && idx_a != 4'd6; w++) @(negedge clk);
        check_eq("mid:idx6", int'(idx_a), 6, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid:out_valid", int'(bus_a.out_valid), 0, 0);
        check_eq("mid:x_out", s16(bus_a.x_out), 0, 0);
        check_eq("mid:y_out", s16(bus_a.y_out), 0, 0);
        check_eq("mid:z_out", s16(bus_a.z_out), 0, 0);
        check_eq("mid:rom_idx", int'(idx_a), 0, 0);
        check_eq("mid:in_ready_low", int'(bus_a.in_ready), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid:in_ready_after", int'(bus_a.in_ready), 1, 0);
        hits = 0;
        for (int c = 0; c < ITERS_A + 6; c++) begin
            if (bus_a.out_valid) hits++;
            @(negedge clk);
        end
        check_eq("mid:no_result", hits, 0, 0);
        run_a(16'h0800, 16'hFC00, 16'h0200, 1, "after_rst", xo, yo, zo);

        // 16-iteration instance: index reaches 15, zero ROM entries keep z
        ref_rotate(16'h0900, 16'h0200, 16'hFA00, ITERS_B, GAIN, ex, ey, ez);
        ref_rotate(16'h0900, 16'h0200, 16'hFA00, 13, 1'b0, ex13, ey13, ez13);
        @(negedge clk);
        bus_b.x_in = 16'h0900; bus_b.y_in = 16'h0200; bus_b.z_in = 16'hFA00;
        bus_b.in_valid = 1'b1;
        for (int w = 0; w < 8 && !bus_b.in_ready; w++) @(negedge clk);
        check_eq("i16:accept_ready", int'(bus_b.in_ready), 1, 0);
        @(posedge clk);
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= ITERS_B + 10; c++) begin
            if (bus_b.out_valid) begin
                lat = c;
                break;
            end
            if (c <= ITERS_B) check_eq("i16:rom_idx", int'(idx_b), c - 1, 0);
            @(negedge clk);
        end
        check_eq("i16:latency", lat, ITERS_B + 1 + EXTRA, 0);
        check_eq("i16:x", s16(bus_b.x_out), ex, 0);
        check_eq("i16:y", s16(bus_b.y_out), ey, 0);
        check_eq("i16:z_unchanged", s16(bus_b.z_out), ez13, 0);
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        bus_b.out_ready = 1'b0;
        check_eq("i16:post_ready", int'(bus_b.in_ready), 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
